cdb_arbiter: RTL and testbench

Completion-side arbiter for the common data bus (CDB). Each functional unit (LSU, MULT, BTU, ALU) hands finished results to a small per-unit completion FIFO. The block then grants exactly one result per cycle to the CDB using round-robin priority. It sits between the FU outputs and the CDB consumers (RS wakeup, ROB, map table), so FUs with unpredictable latency can complete without pre-reserving a CDB slot.

---
 rtl/cdb_arbiter.sv | 155 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Completion-side CDB arbiter.
// Each functional unit pushes finished results into its own small completion
// FIFO; one head entry per cycle is granted onto the common data bus using
// round-robin priority. CDB outputs are driven from registered FIFO state so a
// result pushed at one clock edge is visible on the bus in the following cycle.
module cdb_arbiter #(
  parameter int NUM_FU      = 4,
  parameter int FIFO_DEPTH  = 2,
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = 6
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [NUM_FU-1:0]                      fu_valid,
  input  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]     fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]            fu_value,
  output logic [NUM_FU-1:0]                      fu_ready,
  output logic                                   cdb_valid,
  output logic [ROB_TAG_LEN-1:0]                 cdb_tag,
  output logic [XLEN-1:0]                        cdb_value,
  output logic [((NUM_FU > 1) ? $clog2(NUM_FU) : 1)-1:0] cdb_fu
);

  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO state: pointers wrap naturally because the depth is a power of two.
  logic [PTR_W-1:0]       head_r    [NUM_FU];
  logic [PTR_W-1:0]       tail_r    [NUM_FU];
  logic [CNT_W-1:0]       count_r   [NUM_FU];
  logic [ROB_TAG_LEN-1:0] tag_mem_r [NUM_FU][FIFO_DEPTH];
  logic [XLEN-1:0]        value_mem_r [NUM_FU][FIFO_DEPTH];
  logic [FU_W-1:0]        rr_ptr_r;

  logic                   active_s;
  logic [NUM_FU-1:0]      push_s;
  logic [NUM_FU-1:0]      pop_s;
  logic                   found_s;
  logic                   grant_s;
  logic [FU_W-1:0]        winner_s;
  logic [FU_W-1:0]        cand_s;
  logic [FU_W-1:0]        next_rr_s;
  int                     scan_idx_s;

  // Reset and flush both suppress every push, pop and broadcast in their cycle.
  assign active_s = !reset && !flush;

  // Ready comes only from registered counts plus reset/flush, never from the grant.
  always_comb begin
    fu_ready = {NUM_FU{1'b0}};
    push_s   = {NUM_FU{1'b0}};
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (count_r[i] < CNT_W'(FIFO_DEPTH)) && active_s;
      push_s[i]   = fu_valid[i] && fu_ready[i];
    end
  end

  // Round-robin scan from rr_ptr_r; first non-empty FIFO wins.
  always_comb begin
    found_s    = 1'b0;
    winner_s   = {FU_W{1'b0}};
    cand_s     = {FU_W{1'b0}};
    scan_idx_s = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_idx_s = int'(rr_ptr_r) + k;
      if (scan_idx_s >= NUM_FU) begin
        scan_idx_s = scan_idx_s - NUM_FU;
      end else begin
        scan_idx_s = scan_idx_s;
      end
      cand_s = FU_W'(scan_idx_s);
      if (!found_s && (count_r[cand_s] != {CNT_W{1'b0}})) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign grant_s = found_s && active_s;

  // Pop strobe per FIFO and the pointer value following the current winner.
  always_comb begin
    pop_s = {NUM_FU{1'b0}};
    for (int i = 0; i < NUM_FU; i++) begin
      pop_s[i] = grant_s && (winner_s == FU_W'(i));
    end
    if (winner_s == FU_W'(NUM_FU - 1)) begin
      next_rr_s = {FU_W{1'b0}};
    end else begin
      next_rr_s = winner_s + FU_W'(1);
    end
  end

  // Broadcast the winner's head entry; idle bus is all zeros.
  always_comb begin
    if (grant_s) begin
      cdb_valid = 1'b1;
      cdb_tag   = tag_mem_r[winner_s][head_r[winner_s]];
      cdb_value = value_mem_r[winner_s][head_r[winner_s]];
      cdb_fu    = winner_s;
    end else begin
      cdb_valid = 1'b0;
      cdb_tag   = {ROB_TAG_LEN{1'b0}};
      cdb_value = {XLEN{1'b0}};
      cdb_fu    = {FU_W{1'b0}};
    end
  end

  // FIFO storage, pointers, counts and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head_r[i]  <= {PTR_W{1'b0}};
        tail_r[i]  <= {PTR_W{1'b0}};
        count_r[i] <= {CNT_W{1'b0}};
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          tag_mem_r[i][j]   <= {ROB_TAG_LEN{1'b0}};
          value_mem_r[i][j] <= {XLEN{1'b0}};
        end
      end
      rr_ptr_r <= {FU_W{1'b0}};
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head_r[i]  <= {PTR_W{1'b0}};
        tail_r[i]  <= {PTR_W{1'b0}};
        count_r[i] <= {CNT_W{1'b0}};
      end
      rr_ptr_r <= {FU_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push_s[i]) begin
          tag_mem_r[i][tail_r[i]]   <= fu_tag[i];
          value_mem_r[i][tail_r[i]] <= fu_value[i];
          tail_r[i]                 <= tail_r[i] + PTR_W'(1);
        end
        if (pop_s[i]) begin
          head_r[i] <= head_r[i] + PTR_W'(1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
          2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
      if (grant_s) begin
        rr_ptr_r <= next_rr_s;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter (4 FUs, depth-2 FIFOs).
// Each table row is one clock cycle: inputs applied after the rising edge,
// outputs compared at the falling edge. Result values are derived from tags
// so that tag 5 carries value 0xDEAD.
module tb_cdb_arbiter;

  localparam int NUM_FU = 4;
  localparam int XLEN   = 32;
  localparam int TAGW   = 6;

  logic                           clk;
  logic                           reset;
  logic                           flush;
  logic [NUM_FU-1:0]              fu_valid;
  logic [NUM_FU-1:0][TAGW-1:0]    fu_tag;
  logic [NUM_FU-1:0][XLEN-1:0]    fu_value;
  logic [NUM_FU-1:0]              fu_ready;
  logic                           cdb_valid;
  logic [TAGW-1:0]                cdb_tag;
  logic [XLEN-1:0]                cdb_value;
  logic [1:0]                     cdb_fu;

  int n_cmp;
  int n_bad;

  cdb_arbiter #(.NUM_FU(NUM_FU), .FIFO_DEPTH(2), .XLEN(XLEN), .ROB_TAG_LEN(TAGW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value),
    .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_fu(cdb_fu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic            fl;
    logic [3:0]      valid;
    logic [TAGW-1:0] t0, t1, t2, t3;
    logic [3:0]      rdy;
    logic            cv;
    logic [TAGW-1:0] ctag;
    logic [1:0]      cfu;
    int              crr;   // -1: pointer not checked on this row
  } vec_t;

  vec_t vecs[$];

  function automatic logic [XLEN-1:0] val_of(input logic [TAGW-1:0] t);
    return 32'h0000_DEA8 + {26'd0, t};
  endfunction

  function automatic vec_t mk(input logic rst, input logic fl, input logic [3:0] valid,
                              input int t0, input int t1, input int t2, input int t3,
                              input logic [3:0] rdy, input logic cv, input int ctag,
                              input int cfu, input int crr);
    vec_t v;
    v.rst = rst; v.fl = fl; v.valid = valid;
    v.t0 = TAGW'(t0); v.t1 = TAGW'(t1); v.t2 = TAGW'(t2); v.t3 = TAGW'(t3);
    v.rdy = rdy; v.cv = cv; v.ctag = TAGW'(ctag); v.cfu = 2'(cfu); v.crr = crr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic [3:0] valid,
                       input logic [TAGW-1:0] t0, input logic [TAGW-1:0] t1,
                       input logic [TAGW-1:0] t2, input logic [TAGW-1:0] t3);
    reset = rst; flush = fl; fu_valid = valid;
    fu_tag[0] = t0; fu_tag[1] = t1; fu_tag[2] = t2; fu_tag[3] = t3;
    for (int i = 0; i < NUM_FU; i++) fu_value[i] = val_of(fu_tag[i]);
  endtask

  task automatic check_bus(input string name, input logic cv, input logic [TAGW-1:0] t,
                           input logic [1:0] f);
    check({name, "_valid"}, 64'(cdb_valid), 64'(cv));
    check({name, "_tag"},   64'(cdb_tag),   cv ? 64'(t) : 64'd0);
    check({name, "_value"}, 64'(cdb_value), cv ? 64'(val_of(t)) : 64'd0);
    check({name, "_fu"},    64'(cdb_fu),    cv ? 64'(f) : 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drive(1'b1, 1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);

    //                rst   fl    valid    t0  t1  t2  t3   rdy      cv    tag fu rr
    // reset, then single-result latency
    vecs.push_back(mk(1'b1, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b0000, 1'b0, 0,  0, -1));
    vecs.push_back(mk(1'b1, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b0000, 1'b0, 0,  0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b0, 0,  0,  0));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0100, 0,  0,  5,  0,   4'b1111, 1'b0, 0,  0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b1, 5,  2, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b0, 0,  0,  3));
    // bring pointer back to 0, then round-robin fairness
    vecs.push_back(mk(1'b0, 1'b0, 4'b1000, 0,  0,  0,  7,   4'b1111, 1'b0, 0,  0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b1, 7,  3, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 10, 11, 12, 13,  4'b1111, 1'b0, 0,  0,  0));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b1, 10, 0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b1, 11, 1, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b1, 12, 2, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b1, 13, 3, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b1001, 20, 0,  0,  23,  4'b1111, 1'b0, 0,  0,  0));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b1, 20, 0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b1, 23, 3, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b0, 0,  0,  0));
    // flush with FIFOs 0, 2, 3 holding entries and pointer at 2
    vecs.push_back(mk(1'b0, 1'b0, 4'b1110, 0,  31, 32, 33,  4'b1111, 1'b0, 0,  0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0001, 30, 0,  0,  0,   4'b1111, 1'b1, 31, 1, -1));
    vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 0,  0,  0,  0,   4'b0000, 1'b0, 0,  0,  2));
    vecs.push_back(mk(1'b0, 1'b0, 4'b1001, 41, 0,  0,  43,  4'b1111, 1'b0, 0,  0,  0));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b1, 41, 0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b1, 43, 3, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b0, 0,  0,  0));
    // backpressure: FU1 pushes tags 1,2,3 while FU0 competes
    vecs.push_back(mk(1'b0, 1'b0, 4'b0011, 50, 1,  0,  0,   4'b1111, 1'b0, 0,  0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0011, 51, 2,  0,  0,   4'b1111, 1'b1, 50, 0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0011, 52, 3,  0,  0,   4'b1101, 1'b1, 1,  1, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0011, 53, 3,  0,  0,   4'b1110, 1'b1, 51, 0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1101, 1'b1, 2,  1, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b1, 52, 0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b1, 3,  1, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b0, 0,  0,  2));
    // same-cycle push/pop with FIFO0 full
    vecs.push_back(mk(1'b0, 1'b0, 4'b1101, 60, 0,  90, 80,  4'b1111, 1'b0, 0,  0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b1001, 61, 0,  0,  81,  4'b1111, 1'b1, 90, 2, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0001, 62, 0,  0,  0,   4'b0110, 1'b1, 80, 3, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0001, 62, 0,  0,  0,   4'b1110, 1'b1, 60, 0,  0));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0001, 62, 0,  0,  0,   4'b1111, 1'b1, 81, 3, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1110, 1'b1, 61, 0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b1, 62, 0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0,  0,  0,  0,   4'b1111, 1'b0, 0,  0,  1));

    #1;
    for (int r = 0; r < vecs.size(); r++) begin
      drive(vecs[r].rst, vecs[r].fl, vecs[r].valid, vecs[r].t0, vecs[r].t1, vecs[r].t2, vecs[r].t3);
      @(negedge clk);
      check($sformatf("row%0d_ready", r), 64'(fu_ready), 64'(vecs[r].rdy));
      check_bus($sformatf("row%0d", r), vecs[r].cv, vecs[r].ctag, vecs[r].cfu);
      if (vecs[r].crr >= 0) begin
        check($sformatf("row%0d_rr_ptr", r), 64'(dut.rr_ptr_r), 64'(vecs[r].crr));
      end
      @(posedge clk);
      #1;
    end

    // pointer wrap: 10 results through FU3, each broadcast one cycle after its push
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) drive(1'b0, 1'b0, 4'b1000, 6'd0, 6'd0, 6'd0, TAGW'(20 + k));
      else        drive(1'b0, 1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
      @(negedge clk);
      check($sformatf("wrap%0d_ready", k), 64'(fu_ready), 64'hF);
      if (k == 0) check_bus($sformatf("wrap%0d", k), 1'b0, 6'd0, 2'd0);
      else        check_bus($sformatf("wrap%0d", k), 1'b1, TAGW'(20 + k - 1), 2'd3);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    @(negedge clk);
    check_bus("wrap_idle", 1'b0, 6'd0, 2'd0);
    @(posedge clk);
    #1;

    // reset mid-operation: buffered tag 9 from FU1 is lost
    drive(1'b0, 1'b0, 4'b0010, 6'd0, 6'd9, 6'd0, 6'd0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    @(negedge clk);
    check_bus("midrst_during", 1'b0, 6'd0, 2'd0);
    check("midrst_during_ready", 64'(fu_ready), 64'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    @(negedge clk);
    check_bus("midrst_after", 1'b0, 6'd0, 2'd0);
    check("midrst_after_ready", 64'(fu_ready), 64'hF);
    check("midrst_after_rr_ptr", 64'(dut.rr_ptr_r), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_bus("midrst_later", 1'b0, 6'd0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
